binary_to_bcd_converter: RTL

//  Sequential shift-and-add-3 (double-dabble) converter: unsigned binary word -> packed BCD digits.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_adjust.sv | 20 ++
 rtl/binary_to_bcd_converter.sv | 118 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared types/constants for the binary-to-BCD converter
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Double-dabble correction: a digit >= 5 becomes digit + 3 before the shift
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_MIN = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADD3    = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// bcd_digit_adjust : combinational add-3 correction for one BCD digit
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= BCD_ADJ_MIN) ? (digit_i + BCD_ADD3) : digit_i;
  end

endmodule

`default_nettype wire

// File: rtl/binary_to_bcd_converter.sv
// ============================================================================
// binary_to_bcd_converter : sequential double-dabble, start/ready/done handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module binary_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int N      = 13,
  parameter int DIGITS = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic [N-1:0]                  binary_i,
  output logic                          ready_o,
  output logic                          done_o,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic                          overflow_o
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [N-1:0]       shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [BCD_W-1:0]   adj_w;
  logic [BCD_W-1:0]   work_next_w;
  logic               ovf_next_w;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adjust u_adj (
        .digit_i (work_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (adj_w[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Anything leaving the top digit is a decade we cannot represent
  assign work_next_w = {adj_w[BCD_W-2:0], shift_q[N-1]};
  assign ovf_next_w  = ovf_q | adj_w[BCD_W-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    ready_o    = 1'b0;
    done_o     = 1'b0;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          shift_d = binary_i;
          work_d  = '0;
          ovf_d   = 1'b0;
          count_d = CNT_W'(N - 1);
          state_d = OP;
        end
      end
      OP: begin
        shift_d = shift_q << 1;
        work_d  = work_next_w;
        ovf_d   = ovf_next_w;
        if (count_q == '0) begin
          bcd_d      = work_next_w;
          overflow_d = ovf_next_w;
          state_d    = DONE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd_o      = bcd_q;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire
